// File: rtl/decoder_unit_if.sv
// Instruction-decode bus: the instruction word in, the datapath control fields and strobes out.
interface decoder_unit_if;
  logic [15:0] insn;
  logic        sign;
  logic [15:0] imm_mask;
  logic [2:0]  src_a;
  logic [1:0]  src_b;
  logic [5:0]  alu_sel;
  logic        wr_stk1;
  logic        pop;
  logic        push;
  logic        load_stk;
  logic        load_fp;
  logic        load_ip;
  logic        load_isr;
  logic        cpop;
  logic        cpush;
  logic        byt;
  logic        rd_mem;
  logic        wr_mem;
  logic        set_ien;
  logic        clear_ien;

  modport master (
    output insn,
    input  sign, imm_mask, src_a, src_b, alu_sel,
    input  wr_stk1, pop, push, load_stk, load_fp, load_ip, load_isr,
    input  cpop, cpush, byt, rd_mem, wr_mem, set_ien, clear_ien
  );

  modport slave (
    input  insn,
    output sign, imm_mask, src_a, src_b, alu_sel,
    output wr_stk1, pop, push, load_stk, load_fp, load_ip, load_isr,
    output cpop, cpush, byt, rd_mem, wr_mem, set_ien, clear_ien
  );
endinterface

// File: rtl/decoder_unit.sv
// Purely combinational stack-machine instruction decoder. Reset only gates the
// side-effect strobes; the data-path select fields always follow the instruction.
module decoder_unit (
  input  logic           clk,
  input  logic           rst_n,
  decoder_unit_if.slave  bus
);

  localparam logic [2:0] SrcAStk0 = 3'd0;
  localparam logic [2:0] SrcAFp   = 3'd1;
  localparam logic [2:0] SrcAIp   = 3'd2;
  localparam logic [2:0] SrcACstk = 3'd3;
  localparam logic [2:0] SrcABar  = 3'd4;

  localparam logic [1:0] SrcBStk1 = 2'd0;
  localparam logic [1:0] SrcBImm  = 2'd1;
  localparam logic [1:0] SrcBIsr  = 2'd2;

  localparam logic [5:0] AluA   = 6'h00;
  localparam logic [5:0] AluAdd = 6'h04;
  localparam logic [5:0] AluB   = 6'h0F;

  logic        signD;
  logic [15:0] immMaskD;
  logic [2:0]  srcAD;
  logic [1:0]  srcBD;
  logic [5:0]  aluSelD;
  logic        bytD;
  logic        wrStk1D, popD, pushD, loadStkD, loadFpD, loadIpD, loadIsrD;
  logic        cpopD, cpushD, rdMemD, wrMemD, setIenD, clearIenD;
  logic [15:0] insn;

  // clk and insn[8] carry no meaning for this decoder.
  logic [1:0]  unusedBits;
  assign unusedBits = {clk, bus.insn[8]};

  assign insn = bus.insn;

  always_comb begin
    signD     = 1'b0;
    immMaskD  = 16'h0000;
    srcAD     = SrcAStk0;
    srcBD     = SrcBStk1;
    aluSelD   = AluA;
    bytD      = 1'b0;
    wrStk1D   = 1'b0;
    popD      = 1'b0;
    pushD     = 1'b0;
    loadStkD  = 1'b0;
    loadFpD   = 1'b0;
    loadIpD   = 1'b0;
    loadIsrD  = 1'b0;
    cpopD     = 1'b0;
    cpushD    = 1'b0;
    rdMemD    = 1'b0;
    wrMemD    = 1'b0;
    setIenD   = 1'b0;
    clearIenD = 1'b0;

    if (insn[15]) begin
      immMaskD = 16'h7FFF;
      srcBD    = SrcBImm;
      aluSelD  = AluB;
      pushD    = 1'b1;
      loadStkD = 1'b1;
    end else begin
      case (insn[14:12])
        3'b000: begin
          immMaskD = 16'h0FFE;
          signD    = insn[11];
          srcAD    = SrcAIp;
          srcBD    = SrcBImm;
          aluSelD  = AluAdd;
          loadIpD  = 1'b1;
          cpushD   = insn[0];
        end
        3'b010, 3'b011, 3'b100: begin
          // Memory ops share the base-address selection; the opcode picks size and direction.
          srcBD = SrcBImm;
          case (insn[11:10])
            2'b00: aluSelD = AluB;
            2'b01: begin srcAD = SrcABar;  aluSelD = AluAdd; end
            2'b10: begin srcAD = SrcAIp;   aluSelD = AluAdd; end
            default: begin srcAD = SrcACstk; aluSelD = AluAdd; end
          endcase
          if (insn[14:12] == 3'b100) begin
            immMaskD = 16'h03FE;
          end else begin
            immMaskD = 16'h03FF;
            bytD     = 1'b1;
          end
          if (insn[14:12] == 3'b011 || (insn[14:12] == 3'b100 && insn[0])) begin
            wrMemD = 1'b1;
            popD   = 1'b1;
          end else begin
            rdMemD   = 1'b1;
            pushD    = 1'b1;
            loadStkD = 1'b1;
          end
        end
        3'b110: begin
          if (insn[11:10] == 2'b01) begin
            immMaskD = 16'h03FF;
            signD    = insn[9];
            srcAD    = SrcAFp;
            srcBD    = SrcBImm;
            aluSelD  = AluAdd;
            loadFpD  = 1'b1;
          end
        end
        3'b111: begin
          if (!insn[11]) begin
            aluSelD  = insn[5:0];
            loadStkD = 1'b1;
            popD     = insn[6];
            pushD    = insn[7];
          end else begin
            // Byte forms of LDD/STA/STD sit at the odd code just above their word form.
            case (insn[4:0])
              5'h00: begin srcAD = SrcACstk; loadIpD = 1'b1; cpopD = 1'b1; end
              5'h08, 5'h09: begin
                bytD = insn[0]; loadStkD = 1'b1; rdMemD = 1'b1;
              end
              5'h0C, 5'h0D: begin
                bytD = insn[0]; wrStk1D = 1'b1; popD = 1'b1; loadStkD = 1'b1; wrMemD = 1'b1;
              end
              5'h0E, 5'h0F: begin
                bytD = insn[0]; wrStk1D = 1'b1; popD = 1'b1; wrMemD = 1'b1;
              end
              5'h10: begin
                srcAD = SrcAIp; srcBD = SrcBIsr; aluSelD = AluB; loadIpD = 1'b1; cpushD = 1'b1;
              end
              5'h11: begin popD = 1'b1; loadIsrD = 1'b1; end
              5'h12: begin
                srcAD = SrcACstk; loadIpD = 1'b1; cpopD = 1'b1; setIenD = 1'b1;
              end
              5'h13: clearIenD = 1'b1;
              5'h14: setIenD = 1'b1;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sign     = signD;
  assign bus.imm_mask = immMaskD;
  assign bus.src_a    = srcAD;
  assign bus.src_b    = srcBD;
  assign bus.alu_sel  = aluSelD;
  assign bus.byt      = bytD;

  assign bus.wr_stk1   = wrStk1D   & rst_n;
  assign bus.pop       = popD      & rst_n;
  assign bus.push      = pushD     & rst_n;
  assign bus.load_stk  = loadStkD  & rst_n;
  assign bus.load_fp   = loadFpD   & rst_n;
  assign bus.load_ip   = loadIpD   & rst_n;
  assign bus.load_isr  = loadIsrD  & rst_n;
  assign bus.cpop      = cpopD     & rst_n;
  assign bus.cpush     = cpushD    & rst_n;
  assign bus.rd_mem    = rdMemD    & rst_n;
  assign bus.wr_mem    = wrMemD    & rst_n;
  assign bus.set_ien   = setIenD   & rst_n;
  assign bus.clear_ien = clearIenD & rst_n;

endmodule

// File: tb/tb_decoder_unit.sv
// Self-checking bench for decoder_unit: directed cases, reset gating and random
// instructions compared against an opcode-table reference model.
module tb_decoder_unit;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  decoder_unit_if bus ();

  decoder_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {sign, imm_mask, src_a, src_b, alu_sel, byt, 13 strobes}.
  // Strobe bits 12..0: wr_stk1 pop push load_stk load_fp load_ip load_isr cpop cpush rd_mem wr_mem set_ien clear_ien.
  function automatic logic [41:0] observed();
    return {bus.sign, bus.imm_mask, bus.src_a, bus.src_b, bus.alu_sel, bus.byt,
            bus.wr_stk1, bus.pop, bus.push, bus.load_stk, bus.load_fp, bus.load_ip,
            bus.load_isr, bus.cpop, bus.cpush, bus.rd_mem, bus.wr_mem, bus.set_ien,
            bus.clear_ien};
  endfunction

  function automatic logic [41:0] refModel(input logic [15:0] w, input logic rn);
    logic        s = 0;
    logic [15:0] m = 0;
    logic [2:0]  a = 0;
    logic [1:0]  b = 0;
    logic [5:0]  alu = 0;
    logic        by = 0;
    logic [12:0] st = 0;
    int          op = int'(w[15:12]);
    int          code;
    if (op >= 8) begin
      m = 16'h7FFF; b = 1; alu = 6'h0F; st[10] = 1; st[9] = 1;
    end else if (op == 0) begin
      m = 16'h0FFE; s = w[11]; a = 2; b = 1; alu = 6'h04; st[7] = 1; st[4] = w[0];
    end else if (op == 2 || op == 3 || op == 4) begin
      b = 1;
      if (w[11:10] == 0) alu = 6'h0F;
      else begin
        alu = 6'h04;
        a = (w[11:10] == 1) ? 3'd4 : (w[11:10] == 2) ? 3'd2 : 3'd3;
      end
      m  = (op == 4) ? 16'h03FE : 16'h03FF;
      by = (op != 4);
      if (op == 3 || (op == 4 && w[0])) begin st[2] = 1; st[11] = 1; end
      else begin st[3] = 1; st[10] = 1; st[9] = 1; end
    end else if (op == 6 && w[11:10] == 2'b01) begin
      m = 16'h03FF; s = w[9]; a = 1; b = 1; alu = 6'h04; st[8] = 1;
    end else if (op == 7 && !w[11]) begin
      alu = w[5:0]; st[9] = 1; st[11] = w[6]; st[10] = w[7];
    end else if (op == 7) begin
      code = int'(w[4:0]);
      if (code inside {9, 13, 15}) begin by = 1; code = code - 1; end
      case (code)
        0:  begin a = 3; st[7] = 1; st[5] = 1; end
        8:  begin st[9] = 1; st[3] = 1; end
        12: begin st[12] = 1; st[11] = 1; st[9] = 1; st[2] = 1; end
        14: begin st[12] = 1; st[11] = 1; st[2] = 1; end
        16: begin a = 2; b = 2; alu = 6'h0F; st[7] = 1; st[4] = 1; end
        17: begin st[11] = 1; st[6] = 1; end
        18: begin a = 3; st[7] = 1; st[5] = 1; st[1] = 1; end
        19: st[0] = 1;
        20: st[1] = 1;
        default: ;
      endcase
    end
    if (!rn) st = '0;
    return {s, m, a, b, alu, by, st};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] w, input logic rn);
    @(negedge clk);
    bus.insn = w;
    rst_n    = rn;
    #1;
  endtask

  logic [15:0] directed [0:24] = '{
    16'h8BEF, 16'h0020, 16'h0FF1, 16'h2BCE, 16'h3439, 16'h4E20, 16'h4039,
    16'h6420, 16'h7001, 16'h7050, 16'h708F, 16'h7800, 16'h780C, 16'h780E,
    16'h7810, 16'h7811, 16'h7812, 16'h7813, 16'h7814, 16'h1234, 16'h5ABC,
    16'h6820, 16'h781F, 16'h7809, 16'h6E00
  };

  initial begin
    logic [41:0] o;
    logic [15:0] w;
    logic        rn;
    compared   = 0;
    mismatched = 0;
    rst_n    = 1'b0;
    bus.insn = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    o = observed();
    checkOutput("resetState", 64'(o), 64'(refModel(16'h0000, 1'b0)));
    checkOutput("resetStrobes", 64'(o[12:0]), 64'd0);

    foreach (directed[i]) begin
      applyStimulus(directed[i], 1'b1);
      checkOutput($sformatf("dir_%h", directed[i]), 64'(observed()), 64'(refModel(directed[i], 1'b1)));
    end

    applyStimulus(16'h8BEF, 1'b1);
    checkOutput("pushUimm", 64'({bus.push, bus.load_stk, bus.imm_mask}), 64'({2'b11, 16'h7FFF}));
    applyStimulus(16'h0FF1, 1'b1);
    checkOutput("callSign", 64'({bus.sign, bus.cpush, bus.src_a}), 64'({2'b11, 3'd2}));
    applyStimulus(16'h780E, 1'b1);
    checkOutput("stdNoLoad", 64'({bus.load_stk, bus.wr_mem, bus.wr_stk1}), 64'(3'b011));
    applyStimulus(16'h7812, 1'b1);
    checkOutput("iretIen", 64'({bus.set_ien, bus.cpop, bus.clear_ien}), 64'(3'b110));
    applyStimulus(16'h708F, 1'b1);
    checkOutput("stackB", 64'({bus.alu_sel, bus.push, bus.src_b}), 64'({6'h0F, 1'b1, 2'd0}));

    applyStimulus(16'h780C, 1'b0);
    o = observed();
    checkOutput("gateStrobes", 64'(o[12:0]), 64'd0);
    checkOutput("gateFields", 64'({bus.src_a, bus.alu_sel}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("releaseWrMem", 64'(bus.wr_mem), 64'd1);
    checkOutput("releaseAll", 64'(observed()), 64'(refModel(16'h780C, 1'b1)));

    for (int i = 0; i < 600; i++) begin
      w  = 16'($urandom);
      if ($urandom_range(0, 3) != 0) w[15] = 1'b0;
      if ($urandom_range(0, 1) == 1 && w[15:11] == 5'b01111) w[7:5] = 3'b000;
      rn = ($urandom_range(0, 9) != 0);
      applyStimulus(w, rn);
      o = observed();
      checkOutput($sformatf("rnd_%h_%b", w, rn), 64'(o), 64'(refModel(w, rn)));
      checkOutput("ienExclusive", 64'(bus.set_ien & bus.clear_ien), 64'd0);
      checkOutput("pushPopBoth", 64'(bus.push & bus.pop),
                  64'(w[15:11] == 5'b01110 && w[7:6] == 2'b11 && rn));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decoder_unit.md
DECODER_UNIT -- requirements
Module: decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: system clock. The decoder holds no state, so clk drives no logic.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port insn, input, 16 bits: the instruction word.
REQ-005 Port sign, output, 1 bit: sign-extend the masked immediate.
REQ-006 Port imm_mask, output, 16 bits: mask applied to insn to form the immediate.
REQ-007 Port src_a, output, 3 bits: ALU A-source select. Encodings: STK0=0, FP=1, IP=2, CSTK=3, BAR=4.
REQ-008 Port src_b, output, 2 bits: ALU B-source select. Encodings: STK1=0, IMM=1, ISR=2.
REQ-009 Port alu_sel, output, 6 bits: ALU operation. Encodings: A=0x00, INC=0x01, ADD=0x04, B=0x0F, AND=0x10.
REQ-010 1-bit output strobes: wr_stk1, pop, push, load_stk, load_fp, load_ip, load_isr, cpop, cpush, byt, rd_mem, wr_mem, set_ien, clear_ien.

Function
REQ-011 All outputs SHALL be combinational functions of insn and rst_n, with zero latency.
REQ-012 Default values, used unless a row below overrides them:
- sign=0, imm_mask=0x0000, src_a=STK0, src_b=STK1, alu_sel=A, byt=0.
- Every strobe = 0.
REQ-013 insn[15]=1 (PUSH uimm15): imm_mask=0x7FFF, src_b=IMM, alu=B, push=1, load_stk=1.
REQ-014 insn[15:12]=0000 (JMP/CALL): imm_mask=0x0FFE, sign=insn[11], src_a=IP, src_b=IMM, alu=ADD, load_ip=1, cpush=insn[0].
REQ-015 Base field insn[11:10] for memory ops:
- 00 = absolute: alu=B.
- 01 = BAR, 10 = IP, 11 = CSTK: src_a = that base, alu=ADD.
REQ-016 Memory ops always set src_b=IMM and sign=0.
REQ-017 insn[15:12]=0010 (LD1): imm_mask=0x03FF, byt=1, rd_mem=1, push=1, load_stk=1.
REQ-018 insn[15:12]=0011 (ST1): imm_mask=0x03FF, byt=1, wr_mem=1, pop=1.
REQ-019 insn[15:12]=0100 (LD when insn[0]=0, ST when insn[0]=1): imm_mask=0x03FE, byt=0. LD: rd_mem, push, load_stk. ST: wr_mem, pop.
REQ-020 insn[15:12]=0110 with insn[11:10]=01 (ADD fp,simm10): imm_mask=0x03FF, sign=insn[9], src_a=FP, src_b=IMM, alu=ADD, load_fp=1. Other insn[11:10] values SHALL decode to defaults.
REQ-021 insn[15:11]=01110 (stack ALU op):
- src_a=STK0, src_b=STK1, alu_sel=insn[5:0], load_stk=1.
- pop=insn[6], push=insn[7].
REQ-022 insn[15:11]=01111 (system op), selected by insn[4:0]; byte variants set byt=1 and are otherwise identical to their word form:

| insn[4:0] | Op | Outputs |
|---|---|---|
| 0x00 | RET | src_a=CSTK, alu=A, load_ip, cpop |
| 0x08 | LDD | src_a=STK0, alu=A, load_stk, rd_mem |
| 0x09 | LDD1 | as LDD, byt=1 |
| 0x0C | STA | src_a=STK0, alu=A, wr_stk1, pop, load_stk, wr_mem |
| 0x0D | STA1 | as STA, byt=1 |
| 0x0E | STD | src_a=STK0, alu=A, wr_stk1, pop, wr_mem; load_stk=0 |
| 0x0F | STD1 | as STD, byt=1 |
| 0x10 | INT | src_a=IP, src_b=ISR, alu=B, load_ip, cpush; set_ien=clear_ien=0 |
| 0x11 | ISR | src_a=STK0, alu=A, pop, load_isr |
| 0x12 | IRET | src_a=CSTK, alu=A, load_ip, cpop, set_ien |
| 0x13 | CLI | clear_ien |
| 0x14 | STI | set_ien |

REQ-023 Unlisted encodings SHALL decode to defaults (NOP). These include opcodes 0001, 0101, the remaining 0110 forms, and unlisted 01111 codes.
REQ-024 set_ien and clear_ien SHALL never be 1 simultaneously.
REQ-025 push and pop SHALL never be 1 simultaneously, except when insn[7:6]=11 in a stack ALU op, which is passed through.

Reset
REQ-026 While rst_n=0, every 1-bit strobe SHALL be forced to 0 asynchronously. The strobes are wr_stk1, pop, push, load_stk, load_fp, load_ip, load_isr, cpop, cpush, rd_mem, wr_mem, set_ien, clear_ien.
REQ-027 While rst_n=0, sign, imm_mask, src_a, src_b, alu_sel and byt SHALL still follow insn.
REQ-028 On rst_n rising, outputs SHALL reflect insn immediately, with no clock edge required.

Verification
REQ-029 insn=0x8BEF -> imm_mask=0x7FFF, src_b=IMM, alu=B, push=1, load_stk=1, other strobes 0, sign=0.
REQ-030 insn=0x0020 -> sign=0, imm_mask=0x0FFE, src_a=IP, alu=ADD, load_ip=1, cpush=0. insn=0x0FF1 -> same outputs but sign=1 and cpush=1.
REQ-031 Memory ops:
- 0x2BCE -> src_a=IP, byt=1, rd_mem=1, push=1, mask=0x03FF.
- 0x3439 -> src_a=BAR, byt=1, wr_mem=1, pop=1.
- 0x4E20 -> src_a=CSTK, mask=0x03FE, rd_mem=1.
- 0x4039 -> alu=B, wr_mem=1, pop=1.
REQ-032 ALU and stack ops:
- 0x6420 -> src_a=FP, load_fp=1.
- 0x7001 -> alu=0x01, load_stk=1, pop=0.
- 0x7050 -> alu=0x10, pop=1.
- 0x708F -> alu=B, src_b=STK1, push=1.
REQ-033 System ops:
- 0x7800 -> cpop=1, load_ip=1.
- 0x780C -> wr_stk1=1, pop=1, load_stk=1, wr_mem=1.
- 0x780E -> same as 0x780C but load_stk=0.
- 0x7810 -> src_b=ISR, cpush=1.
- 0x7811 -> load_isr=1, pop=1.
- 0x7812 -> set_ien=1, cpop=1.
REQ-034 Reset gating: rst_n=0 with insn=0x780C -> all strobes 0 while src_a=STK0 and alu=A. Releasing rst_n restores wr_mem=1 with no clock edge.
